// File: rtl/ternary_mul_seq.sv
// Sequential balanced-ternary multiplier: drives a shared ADD/SUB ternary ALU
// with shift-and-add over WIDTH steps to form a 2*WIDTH-trit signed product.

package ternary_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS     = 2'b01;
  localparam trit_t T_NEG     = 2'b10;
  localparam trit_t T_INVALID = 2'b11;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
endpackage

module ternary_mul_seq
  import ternary_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  trit_t [WIDTH-1:0]        in_a,
  input  trit_t [WIDTH-1:0]        in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trit_t [2*WIDTH-1:0]      out_prod,
  output logic                     out_err,
  output trit_t [WIDTH-1:0]        alu_a,
  output trit_t [WIDTH-1:0]        alu_b,
  output logic  [2:0]              alu_op,
  input  trit_t [WIDTH-1:0]        alu_result,
  input  trit_t                    alu_carry
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state, state_nxt;
  trit_t [WIDTH-1:0]    mcand, mcand_nxt;
  trit_t [WIDTH-1:0]    p_hi, p_hi_nxt;
  trit_t [WIDTH-1:0]    p_lo, p_lo_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 err, err_nxt;
  trit_t [2*WIDTH-1:0]  prod_nxt;
  logic                 oerr_nxt;
  trit_t [WIDTH-1:0]    sum;
  trit_t                carry;

  function automatic logic any_invalid(input trit_t [WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i] == T_INVALID) r = 1'b1;
    return r;
  endfunction

  // Next-state, datapath and ALU drive; the ALU is only exercised in CALC
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    p_hi_nxt  = p_hi;
    p_lo_nxt  = p_lo;
    cnt_nxt   = cnt;
    err_nxt   = err;
    prod_nxt  = out_prod;
    oerr_nxt  = out_err;
    alu_op    = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    sum       = p_hi;
    carry     = T_ZERO;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          mcand_nxt = in_a;
          p_hi_nxt  = '0;
          p_lo_nxt  = in_b;
          cnt_nxt   = '0;
          err_nxt   = any_invalid(in_a) | any_invalid(in_b);
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // Invalid multiplier digits act as zero; err masks the product anyway
        if (p_lo[0] == T_POS || p_lo[0] == T_NEG) begin
          alu_op = (p_lo[0] == T_NEG) ? OP_SUB : OP_ADD;
          alu_a  = p_hi;
          alu_b  = mcand;
          sum    = alu_result;
          carry  = alu_carry;
        end
        p_hi_nxt = {carry, sum[WIDTH-1:1]};
        p_lo_nxt = {sum[0], p_lo[WIDTH-1:1]};
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = S_DONE;
          prod_nxt  = err ? '0 : {p_hi_nxt, p_lo_nxt};
          oerr_nxt  = err;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      p_hi      <= p_hi_nxt;
      p_lo      <= p_lo_nxt;
      cnt       <= cnt_nxt;
      err       <= err_nxt;
      out_prod  <= prod_nxt;
      out_err   <= oerr_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_ternary_mul_seq.sv
// Randomized self-checking bench for ternary_mul_seq with an arithmetic ALU
// model and integer-product reference.

module tb_ternary_mul_seq;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*W-1:0]    in_a;
  logic [2*W-1:0]    in_b;
  logic              out_valid;
  logic              out_ready;
  logic [4*W-1:0]    out_prod;
  logic              out_err;
  logic [2*W-1:0]    alu_a;
  logic [2*W-1:0]    alu_b;
  logic [2:0]        alu_op;
  logic [2*W-1:0]    alu_result;
  logic [1:0]        alu_carry;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ternary_mul_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_err    (out_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  // Trit vector (01=+1, 10=-1, 00/11=0) to integer
  function automatic longint t2i(input logic [63:0] v, input int n);
    longint r;
    logic [1:0] t;
    r = 0;
    for (int i = n - 1; i >= 0; i--) begin
      t = v[2*i +: 2];
      r = r * 3;
      if (t == 2'b01) r = r + 1;
      else if (t == 2'b10) r = r - 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] i2t(input longint x, input int n);
    logic [63:0] v;
    longint rem;
    v = '0;
    for (int i = 0; i < n; i++) begin
      rem = ((x % 3) + 3) % 3;
      if (rem == 1) begin
        v[2*i +: 2] = 2'b01;
        x = (x - 1) / 3;
      end else if (rem == 2) begin
        v[2*i +: 2] = 2'b10;
        x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return v;
  endfunction

  function automatic logic has_invalid(input logic [2*W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < W; i++)
      if (v[2*i +: 2] == 2'b11) r = 1'b1;
    return r;
  endfunction

  function automatic logic [2*W+1:0] alu_model(input logic [2*W-1:0] a,
                                                input logic [2*W-1:0] b,
                                                input logic [2:0] op);
    longint s, lim, c;
    logic [63:0] rv, cv;
    lim = 1;
    for (int i = 0; i < W; i++) lim = lim * 3;
    s = (op == 3'b001) ? t2i(64'(a), W) - t2i(64'(b), W)
                       : t2i(64'(a), W) + t2i(64'(b), W);
    c = 0;
    if (s > (lim - 1) / 2) c = 1;
    else if (s < -((lim - 1) / 2)) c = -1;
    s = s - c * lim;
    rv = i2t(s, W);
    cv = i2t(c, 1);
    return {cv[1:0], rv[2*W-1:0]};
  endfunction

  assign {alu_carry, alu_result} = alu_model(alu_a, alu_b, alu_op);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction; noise drives in_valid junk and stalls out_ready in DONE
  task automatic do_op(input logic [2*W-1:0] av, input logic [2*W-1:0] bv,
                       input bit noise, input string tag);
    logic        err_exp;
    longint      prod_exp;
    logic [63:0] prod_vec;
    int          n;
    err_exp  = has_invalid(av) | has_invalid(bv);
    prod_exp = err_exp ? 0 : t2i(64'(av), W) * t2i(64'(bv), W);
    prod_vec = err_exp ? 64'd0 : i2t(prod_exp, 2*W);

    @(negedge clk);
    out_ready = noise ? 1'b0 : 1'b1;
    in_valid  = 1'b1;
    in_a      = av;
    in_b      = bv;
    #1 check_eq({tag, "_rdy_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = noise;
    if (noise) begin
      in_a = 16'(i2t(longint'($urandom_range(0, 6560)) - 3280, W));
      in_b = in_a;
    end
    check_eq({tag, "_rdy_calc"}, 64'(in_ready), 64'd0);
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(W + 1));
    check_eq({tag, "_prod"}, 64'(out_prod), prod_vec);
    check_eq({tag, "_err"}, 64'(out_err), 64'(err_exp));
    if (noise) begin
      repeat (5) begin
        @(posedge clk);
        #1;
        check_eq({tag, "_hold_v"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_hold_p"}, 64'(out_prod), prod_vec);
        check_eq({tag, "_hold_r"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_hs_v"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_hs_r"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_alu_idle"}, {61'd0, alu_op}, 64'd0);
  endtask

  function automatic logic [2*W-1:0] rand_trits(input bit allow_bad);
    logic [2*W-1:0] v;
    int r;
    for (int i = 0; i < W; i++) begin
      r = int'($urandom_range(0, 2));
      v[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
    end
    if (allow_bad && $urandom_range(0, 7) == 0)
      v[2*$urandom_range(0, W-1) +: 2] = 2'b11;
    return v;
  endfunction

  initial begin
    logic [2*W-1:0] bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_err", 64'(out_err), 64'd0);
    check_eq("rst_out_prod", 64'(out_prod), 64'd0);
    check_eq("rst_alu_a", 64'(alu_a), 64'd0);
    rst_n = 1'b1;

    do_op(16'(i2t(5, W)), 16'(i2t(3, W)), 1'b0, "m5x3");
    do_op(16'(i2t(-1, W)), 16'(i2t(-1, W)), 1'b0, "mn1xn1");
    do_op(16'(i2t(0, W)), 16'(i2t(3280, W)), 1'b0, "m0xmax");
    do_op(16'(i2t(3280, W)), 16'(i2t(3280, W)), 1'b0, "mmaxxmax");
    do_op(16'(i2t(3280, W)), 16'(i2t(-3280, W)), 1'b0, "mmaxxmin");
    bad = 16'(i2t(5, W));
    bad[7:6] = 2'b11;
    do_op(bad, 16'(i2t(3, W)), 1'b0, "minv");
    do_op(16'(i2t(-3280, W)), 16'(i2t(1234, W)), 1'b1, "mstall");

    // Async reset in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'(i2t(100, W));
    in_b     = 16'(i2t(-55, W));
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_rdy", 64'(in_ready), 64'd1);
    check_eq("midrst_vld", 64'(out_valid), 64'd0);
    check_eq("midrst_prod", 64'(out_prod), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'(i2t(-7, W)), 16'(i2t(2, W)), 1'b0, "mn7x2");

    for (int k = 0; k < 24; k++)
      do_op(rand_trits(1'b1), rand_trits(1'b1), (k % 6) == 5, "rnd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
